// File: rtl/coreabc_iram_loader.sv
// coreabc_iram_loader: streams boot words into the instruction RAM init port and raises INITDONE.
// Define IRAM_LOADER_CHECKSUM_EN to require a zero-sum trailer word (CHECK/FAIL states, live ERROR).
module coreabc_iram_loader #(
  parameter int INITWIDTH     = 12,
  parameter int INITDATAWIDTH = 9,
  parameter int NWORDS        = 1536
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     START,
  input  logic [INITDATAWIDTH-1:0] S_DATA,
  input  logic                     S_VALID,
  output logic                     S_READY,
  output logic [INITWIDTH-1:0]     INITADDR,
  output logic [INITDATAWIDTH-1:0] INITDATA,
  output logic                     INITDATVAL,
  output logic                     INITDONE,
  output logic                     BUSY,
  output logic                     ERROR
);
`ifdef IRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, FAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  localparam logic [INITWIDTH-1:0] LAST = INITWIDTH'(NWORDS - 1);
  state_t                   r_state, w_next;
  logic [INITWIDTH-1:0]     r_cnt, r_addr;
  logic [INITDATAWIDTH-1:0] r_data;
  logic                     r_val, r_done, r_busy;
  logic                     w_acc, w_last, w_enter;
  assign w_acc   = S_VALID && (r_state == LOAD);
  assign w_last  = (r_cnt == LAST);
  assign w_enter = (w_next == LOAD) && (r_state != LOAD);
`ifdef IRAM_LOADER_CHECKSUM_EN
  logic [INITDATAWIDTH-1:0] r_sum, w_sum;
  logic                     r_err;
  assign w_sum   = r_sum + S_DATA;
  assign S_READY = (r_state == LOAD) || (r_state == CHECK);
  assign ERROR   = r_err;
`else
  assign S_READY = (r_state == LOAD);
  assign ERROR   = 1'b0;
`endif
  assign INITADDR   = r_addr;
  assign INITDATA   = r_data;
  assign INITDATVAL = r_val;
  assign INITDONE   = r_done;
  assign BUSY       = r_busy;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (START) w_next = LOAD;
`ifdef IRAM_LOADER_CHECKSUM_EN
      LOAD:  if (w_acc && w_last) w_next = CHECK;
      CHECK: if (S_VALID) w_next = (w_sum == '0) ? DONE : FAIL;
      FAIL:  if (START) w_next = LOAD;
`else
      LOAD:  if (w_acc && w_last) w_next = DONE;
`endif
      DONE: if (START) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_val   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_enter ? '0 : (w_acc && !w_last) ? r_cnt + 1'b1 : r_cnt;
      if (w_acc) begin
        r_addr <= r_cnt;
        r_data <= S_DATA;
      end
      r_val  <= w_acc;
      // Entering DONE straight from LOAD waits one cycle so the last strobe never overlaps INITDONE
      r_done <= (w_next == DONE) && (r_state != LOAD);
`ifdef IRAM_LOADER_CHECKSUM_EN
      r_busy <= (w_next == LOAD) || (w_next == CHECK);
`else
      r_busy <= (w_next == LOAD);
`endif
    end
  end
`ifdef IRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      r_sum <= w_enter ? '0 : (S_VALID && S_READY) ? w_sum : r_sum;
      r_err <= (w_next == FAIL);
    end
  end
`endif
endmodule

// File: tb/tb_coreabc_iram_loader.sv
// tb_coreabc_iram_loader: table-driven checks of the IRAM loader (NWORDS=4) plus reset and NWORDS=1 sequences.
module tb_coreabc_iram_loader;
  typedef struct {
    logic st, vl;
    logic [8:0] d;
    logic rdy, val;
    logic [11:0] a;
    logic [8:0] q;
    logic dn, bsy, err;
  } vec_t;
  logic clk = 0, rstn = 0;
  logic start, valid, ready, dval, done, busy, err;
  logic [8:0] sdata, idata;
  logic [11:0] iaddr;
  logic s1_start, s1_valid, s1_ready, s1_dval, s1_done, s1_busy, s1_err;
  logic [8:0] s1_data, s1_idata;
  logic [11:0] s1_addr;
  int checks = 0, errors = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  coreabc_iram_loader #(.INITWIDTH(12), .INITDATAWIDTH(9), .NWORDS(4)) u4 (
    .CLK(clk), .RSTN(rstn), .START(start), .S_DATA(sdata), .S_VALID(valid), .S_READY(ready),
    .INITADDR(iaddr), .INITDATA(idata), .INITDATVAL(dval), .INITDONE(done), .BUSY(busy), .ERROR(err));
  coreabc_iram_loader #(.INITWIDTH(12), .INITDATAWIDTH(9), .NWORDS(1)) u1 (
    .CLK(clk), .RSTN(rstn), .START(s1_start), .S_DATA(s1_data), .S_VALID(s1_valid), .S_READY(s1_ready),
    .INITADDR(s1_addr), .INITDATA(s1_idata), .INITDATVAL(s1_dval), .INITDONE(s1_done), .BUSY(s1_busy), .ERROR(s1_err));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask
  task automatic add(input logic st, input logic vl, input logic [8:0] d, input logic rdy, input logic val,
                     input logic [11:0] a, input logic [8:0] q, input logic dn, input logic bsy, input logic e);
    vec_t t;
    t.st = st; t.vl = vl; t.d = d; t.rdy = rdy; t.val = val; t.a = a; t.q = q; t.dn = dn; t.bsy = bsy; t.err = e;
    v.push_back(t);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load4(input logic [8:0] w0, input logic [8:0] w1, input logic [8:0] w2, input logic [8:0] w3,
                       input logic last_ready);
    add(1, 0, 9'h000, 1, 0, 12'd0, 9'h000, 0, 1, 0);
    add(0, 1, w0, 1, 1, 12'd0, w0, 0, 1, 0);
    add(0, 1, w1, 1, 1, 12'd1, w1, 0, 1, 0);
    add(0, 1, w2, 1, 1, 12'd2, w2, 0, 1, 0);
    add(0, 1, w3, last_ready, 1, 12'd3, w3, 0, last_ready, 0);
  endtask
  initial begin
    start = 1; valid = 0; sdata = '0;
    s1_start = 1; s1_valid = 0; s1_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0); chk("rst_val", dval, 0); chk("rst_done", done, 0);
    chk("rst_busy", busy, 0); chk("rst_err", err, 0); chk("rst_addr", iaddr, 0); chk("rst_data", idata, 0);
    chk("rst1_busy", s1_busy, 0); chk("rst1_ready", s1_ready, 0);
    rstn = 1; start = 0; s1_start = 0;
    step();
    chk("idle_ready", ready, 0); chk("idle_busy", busy, 0);
`ifdef IRAM_LOADER_CHECKSUM_EN
    load4(9'h001, 9'h002, 9'h003, 9'h004, 1);
    add(0, 1, 9'h1F6, 0, 0, 12'd3, 9'h004, 1, 0, 0);
    add(0, 0, 9'h000, 0, 0, 12'd3, 9'h004, 1, 0, 0);
    add(1, 0, 9'h000, 1, 0, 12'd3, 9'h004, 0, 1, 0);
    add(0, 1, 9'h0AA, 1, 1, 12'd0, 9'h0AA, 0, 1, 0);
    add(0, 0, 9'h1FF, 1, 0, 12'd0, 9'h0AA, 0, 1, 0);
    add(1, 1, 9'h0AA, 1, 1, 12'd1, 9'h0AA, 0, 1, 0);
    add(0, 0, 9'h000, 1, 0, 12'd1, 9'h0AA, 0, 1, 0);
    add(0, 1, 9'h0AA, 1, 1, 12'd2, 9'h0AA, 0, 1, 0);
    add(0, 0, 9'h000, 1, 0, 12'd2, 9'h0AA, 0, 1, 0);
    add(0, 1, 9'h0AA, 1, 1, 12'd3, 9'h0AA, 0, 1, 0);
    add(0, 1, 9'h158, 0, 0, 12'd3, 9'h0AA, 1, 0, 0);
    load4(9'h001, 9'h002, 9'h003, 9'h004, 1);
    add(0, 1, 9'h1F7, 0, 0, 12'd3, 9'h004, 0, 0, 1);
    add(0, 0, 9'h000, 0, 0, 12'd3, 9'h004, 0, 0, 1);
    add(1, 0, 9'h000, 1, 0, 12'd3, 9'h004, 0, 1, 0);
`else
    load4(9'h001, 9'h002, 9'h003, 9'h004, 0);
    add(0, 0, 9'h000, 0, 0, 12'd3, 9'h004, 1, 0, 0);
    add(0, 0, 9'h000, 0, 0, 12'd3, 9'h004, 1, 0, 0);
    add(1, 0, 9'h000, 1, 0, 12'd3, 9'h004, 0, 1, 0);
    add(0, 1, 9'h0AA, 1, 1, 12'd0, 9'h0AA, 0, 1, 0);
    add(0, 0, 9'h1FF, 1, 0, 12'd0, 9'h0AA, 0, 1, 0);
    add(1, 1, 9'h0AA, 1, 1, 12'd1, 9'h0AA, 0, 1, 0);
    add(0, 0, 9'h000, 1, 0, 12'd1, 9'h0AA, 0, 1, 0);
    add(0, 1, 9'h0AA, 1, 1, 12'd2, 9'h0AA, 0, 1, 0);
    add(0, 0, 9'h000, 1, 0, 12'd2, 9'h0AA, 0, 1, 0);
    add(0, 1, 9'h0AA, 0, 1, 12'd3, 9'h0AA, 0, 0, 0);
    add(0, 0, 9'h000, 0, 0, 12'd3, 9'h0AA, 1, 0, 0);
    add(0, 0, 9'h000, 0, 0, 12'd3, 9'h0AA, 1, 0, 0);
`endif
    foreach (v[i]) begin
      start = v[i].st; valid = v[i].vl; sdata = v[i].d;
      step();
      chk($sformatf("row%0d_ready", i), ready, v[i].rdy);
      chk($sformatf("row%0d_val", i), dval, v[i].val);
      chk($sformatf("row%0d_addr", i), iaddr, v[i].a);
      chk($sformatf("row%0d_data", i), idata, v[i].q);
      chk($sformatf("row%0d_done", i), done, v[i].dn);
      chk($sformatf("row%0d_busy", i), busy, v[i].bsy);
      chk($sformatf("row%0d_err", i), err, v[i].err);
    end
    start = 1; valid = 0; step();
    start = 0; valid = 1; sdata = 9'h011; step();
    sdata = 9'h022; step();
    chk("mid_addr", iaddr, 1); chk("mid_val", dval, 1); chk("mid_busy", busy, 1);
    rstn = 0; valid = 0; #1;
    chk("arst_val", dval, 0); chk("arst_done", done, 0); chk("arst_busy", busy, 0);
    chk("arst_ready", ready, 0); chk("arst_addr", iaddr, 0); chk("arst_data", idata, 0);
    step();
    rstn = 1;
    repeat (2) begin
      step();
      chk("post_rst_ready", ready, 0); chk("post_rst_busy", busy, 0); chk("post_rst_val", dval, 0);
    end
    start = 1; step();
    start = 0; valid = 1; sdata = 9'h033; step();
    valid = 0;
    chk("restart_addr", iaddr, 0); chk("restart_data", idata, 9'h033); chk("restart_val", dval, 1);
    s1_start = 1; step();
    s1_start = 0;
    chk("n1_ready", s1_ready, 1); chk("n1_busy", s1_busy, 1);
    s1_valid = 1; s1_data = 9'h155; step();
    chk("n1_val", s1_dval, 1); chk("n1_addr", s1_addr, 0); chk("n1_data", s1_idata, 9'h155);
    chk("n1_done_early", s1_done, 0);
`ifdef IRAM_LOADER_CHECKSUM_EN
    chk("n1_chk_ready", s1_ready, 1);
    s1_data = 9'h0AB; step();
    s1_valid = 0;
    chk("n1_trailer_val", s1_dval, 0);
    chk("n1_done", s1_done, 1); chk("n1_err", s1_err, 0);
`else
    chk("n1_busy_end", s1_busy, 0);
    s1_valid = 0; step();
    chk("n1_val_end", s1_dval, 0);
    chk("n1_done", s1_done, 1);
`endif
    step();
    chk("n1_done_hold", s1_done, 1); chk("n1_addr_hold", s1_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
